rcc_multi_pclk_timer_div: RTL and testbench

- Parametrised successor of the single APB prescaler and timer-kernel divider.
- Generates NCH independent bus-clock dividers and their timer-kernel dividers from one free-running counter on i_clk, so all channels stay phase-aligned.
- Ratio changes are shadowed and applied only at a period boundary, with a per-channel busy/done handshake.
- Sits in RCC between the AHB clock root and the APB bridges and timer blocks.

---
 rtl/rcc_multi_pclk_timer_div.sv | 166 ++++++++++++++++
 tb/tb_rcc_multi_pclk_timer_div.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rcc_multi_pclk_timer_div.sv
`default_nettype none
// ============================================================================
// Module   : rcc_multi_pclk_timer_div
// Brief    : NCH phase-aligned bus-clock and timer-kernel dividers driven
//            from one shared free-running counter. Ratio changes are shadowed
//            and applied at a common period boundary with a busy/done
//            handshake per channel.
// Options  : RCC_PCLK_GATE_EN adds gate_req[NCH], a per-channel clock gate
//            latched only at bus-period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module rcc_multi_pclk_timer_div #(
  parameter int NCH   = 2,
  parameter int SEL_W = 3
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic [NCH*SEL_W-1:0]   div_sel,
  input  logic [NCH-1:0]         timpre,
`ifdef RCC_PCLK_GATE_EN
  input  logic [NCH-1:0]         gate_req,
`endif
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         upd_done,
  output logic [NCH-1:0]         div_en,
  output logic [NCH-1:0]         pclk_en,
  output logic [NCH-1:0]         pclk_div,
  output logic [NCH-1:0]         tim_div_en,
  output logic [NCH-1:0]         tim_en,
  output logic [NCH-1:0]         tim_clk_div
);

  // Counter width is tied to the largest log2 ratio so every mask divides 2^CNT_W
  localparam int CNT_W = 2 ** (SEL_W - 1);
  // A log2 ratio ranges 0..2^(SEL_W-1), which needs SEL_W bits
  localparam int LW    = SEL_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  // Mask 2^l-1: all low bits set within one period of ratio 2^l
  function automatic logic [CNT_W-1:0] f_mask(input logic [LW-1:0] l);
    logic [CNT_W:0] m;
    m = (CNT_W+1)'(1) << l;
    m = m - (CNT_W+1)'(1);
    return m[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] r_cnt;

  // Shared free-running counter keeps every channel phase-aligned
  always_ff @(posedge i_clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + CNT_W'(1);
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SEL_W-1:0] w_sel;
    logic [LW-1:0]    w_l_in, w_t_in, w_l_max;
    logic [CNT_W-1:0] w_p_mask, w_t_mask, w_b_mask;
    logic             w_p_hit, w_t_hit, w_p_half, w_t_half, w_bnd, w_same, w_gate;

    logic [0:0]       r_state;
    logic [LW-1:0]    r_l_act, r_t_act, r_l_sh, r_t_sh;
    logic             r_upd, r_den, r_pen, r_pdiv, r_tden, r_ten, r_tdiv;

    assign w_sel = div_sel[c*SEL_W +: SEL_W];

    // Decode the requested bus and timer log2 ratios from the select inputs
    always_comb begin
      w_l_in = '0;
      w_t_in = '0;
      if (w_sel[SEL_W-1]) w_l_in = {1'b0, w_sel[SEL_W-2:0]} + LW'(1);
      if (timpre[c]) begin
        if (w_l_in > LW'(2)) w_t_in = w_l_in - LW'(2);
      end else if (w_l_in != '0) begin
        w_t_in = w_l_in - LW'(1);
      end
    end

    assign w_same   = (w_l_in == r_l_act) && (w_t_in == r_t_act);
    assign w_l_max  = (r_l_act > r_l_sh) ? r_l_act : r_l_sh;
    assign w_b_mask = f_mask(w_l_max);
    assign w_bnd    = (r_cnt & w_b_mask) == w_b_mask;

    assign w_p_mask = f_mask(r_l_act);
    assign w_t_mask = f_mask(r_t_act);
    assign w_p_hit  = (r_cnt & w_p_mask) == w_p_mask;
    assign w_t_hit  = (r_cnt & w_t_mask) == w_t_mask;
    // The mask's top bit is cnt[L-1]; the divided clock is high in the first half-period
    assign w_p_half = (r_l_act != '0) && ((r_cnt & (w_p_mask & ~(w_p_mask >> 1))) == '0);
    assign w_t_half = (r_t_act != '0) && ((r_cnt & (w_t_mask & ~(w_t_mask >> 1))) == '0);

`ifdef RCC_PCLK_GATE_EN
    logic r_gate;
    // Gate request takes effect only at a bus-period boundary so no period is truncated
    always_ff @(posedge i_clk) begin
      if (rst)          r_gate <= 1'b1;
      else if (w_p_hit) r_gate <= gate_req[c];
    end
    assign w_gate = r_gate;
`else
    assign w_gate = 1'b1;
`endif

    // Registered clock outputs and the shadow/apply ratio-change handshake
    always_ff @(posedge i_clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_l_act <= '0;
        r_t_act <= '0;
        r_l_sh  <= '0;
        r_t_sh  <= '0;
        r_upd   <= 1'b0;
        r_den   <= 1'b0;
        r_pen   <= 1'b0;
        r_pdiv  <= 1'b0;
        r_tden  <= 1'b0;
        r_ten   <= 1'b0;
        r_tdiv  <= 1'b0;
      end else begin
        r_den  <= (r_l_act != '0);
        r_tden <= (r_t_act != '0);
        r_pen  <= w_p_hit  & w_gate;
        r_pdiv <= w_p_half & w_gate;
        r_ten  <= w_t_hit  & w_gate;
        r_tdiv <= w_t_half & w_gate;
        r_upd  <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (!w_same) begin
              r_l_sh  <= w_l_in;
              r_t_sh  <= w_t_in;
              r_state <= S_PEND;
            end
          end
          default: begin
            // Boundary of the longer of the old and new periods: both end here
            if (w_bnd) begin
              r_l_act <= r_l_sh;
              r_t_act <= r_t_sh;
              r_upd   <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_same) begin
              r_state <= S_IDLE;
            end else begin
              r_l_sh <= w_l_in;
              r_t_sh <= w_t_in;
            end
          end
        endcase
      end
    end

    assign busy[c]        = (r_state == S_PEND);
    assign upd_done[c]    = r_upd;
    assign div_en[c]      = r_den;
    assign pclk_en[c]     = r_pen;
    assign pclk_div[c]    = r_pdiv;
    assign tim_div_en[c]  = r_tden;
    assign tim_en[c]      = r_ten;
    assign tim_clk_div[c] = r_tdiv;
  end

endmodule
`default_nettype wire

// File: tb/tb_rcc_multi_pclk_timer_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcc_multi_pclk_timer_div
// Brief    : Randomised scoreboard bench; a period/phase arithmetic model
//            predicts every registered output for each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rcc_multi_pclk_timer_div;
  localparam int NCH   = 2;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NCH*SEL_W-1:0] div_sel;
  logic [NCH-1:0]       timpre;
  logic [NCH-1:0]       busy, upd_done, div_en, pclk_en, pclk_div;
  logic [NCH-1:0]       tim_div_en, tim_en, tim_clk_div;

  rcc_multi_pclk_timer_div #(.NCH(NCH), .SEL_W(SEL_W)) dut (
    .i_clk(clk), .rst(rst), .div_sel(div_sel), .timpre(timpre),
    .busy(busy), .upd_done(upd_done), .div_en(div_en), .pclk_en(pclk_en),
    .pclk_div(pclk_div), .tim_div_en(tim_div_en), .tim_en(tim_en),
    .tim_clk_div(tim_clk_div)
  );

  typedef struct packed {
    logic [NCH-1:0] busy, upd, den, pen, pdiv, tden, ten, tdiv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: cycle count, active and requested log2 ratios
  int m_cnt;
  int m_la[NCH], m_ta[NCH], m_ls[NCH], m_ts[NCH];
  bit m_pend[NCH];

  function automatic int dec_l(int s);
    int half = 1 << (SEL_W - 1);
    return (s >= half) ? (s - half + 1) : 0;
  endfunction

  function automatic int dec_t(int l, bit tp);
    int t = tp ? l - 2 : l - 1;
    return (t < 0) ? 0 : t;
  endfunction

  // Predict the outputs seen after the coming edge and advance the model
  task automatic model_step(output exp_t e);
    int per, tper, lin, tin, span;
    e = '0;
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        m_la[c] = 0; m_ta[c] = 0; m_pend[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        per  = 1 << m_la[c];
        tper = 1 << m_ta[c];
        e.pen[c]  = ((m_cnt + 1) % per) == 0;
        e.pdiv[c] = (m_la[c] > 0) && ((m_cnt % per) < per / 2);
        e.ten[c]  = ((m_cnt + 1) % tper) == 0;
        e.tdiv[c] = (m_ta[c] > 0) && ((m_cnt % tper) < tper / 2);
        e.den[c]  = (m_la[c] != 0);
        e.tden[c] = (m_ta[c] != 0);
        lin = dec_l(int'(div_sel[c*SEL_W +: SEL_W]));
        tin = dec_t(lin, timpre[c]);
        if (!m_pend[c]) begin
          if (lin != m_la[c] || tin != m_ta[c]) begin
            m_ls[c] = lin; m_ts[c] = tin; m_pend[c] = 1'b1;
          end
        end else begin
          span = 1 << ((m_la[c] > m_ls[c]) ? m_la[c] : m_ls[c]);
          if (((m_cnt + 1) % span) == 0) begin
            m_la[c] = m_ls[c]; m_ta[c] = m_ts[c];
            m_pend[c] = 1'b0; e.upd[c] = 1'b1;
          end else if (lin == m_la[c] && tin == m_ta[c]) begin
            m_pend[c] = 1'b0;
          end else begin
            m_ls[c] = lin; m_ts[c] = tin;
          end
        end
        e.busy[c] = m_pend[c];
      end
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare registered outputs just after each edge that has a prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy",        busy,        e.busy);
        chk("upd_done",    upd_done,    e.upd);
        chk("div_en",      div_en,      e.den);
        chk("pclk_en",     pclk_en,     e.pen);
        chk("pclk_div",    pclk_div,    e.pdiv);
        chk("tim_div_en",  tim_div_en,  e.tden);
        chk("tim_en",      tim_en,      e.ten);
        chk("tim_clk_div", tim_clk_div, e.tdiv);
      end
    end
  end

  // Stimulus: reset, then random per-channel ratio changes and rare resets
  initial begin
    exp_t e;
    rst     = 1'b1;
    div_sel = '0;
    timpre  = '0;
    repeat (3) begin
      @(negedge clk);
      model_step(e);
      q.push_back(e);
    end
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int c = 0; c < NCH; c++) begin
        if (i > 20 && $urandom_range(0, 11) == 0) begin
          div_sel[c*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 7));
          timpre[c] = 1'($urandom_range(0, 1));
        end
      end
      model_step(e);
      q.push_back(e);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
